// File: rtl/parallel_to_serial.sv
// parallel_to_serial: byte-wide handshake in, MSB-first serial symbol stream out.
// A single holding register decouples the upstream handshake from the shifter.
// Every symbol boundary loads either the held byte (IS_DATA_OUT=1) or the idle
// comma 0xBC (IS_DATA_OUT=0), so symbols are never split and the stream never
// stalls.
// Optional feature: define P2S_PARITY_EN to append an even-parity bit to every
// symbol (symbol length 9 instead of 8).
module parallel_to_serial (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       VALID_IN,
  output logic       READY_OUT,
  output logic       DATA_OUT,
  output logic       SYNC_OUT,
  output logic       IS_DATA_OUT
);

`ifdef P2S_PARITY_EN
  localparam int SYM_L = 9;
`else
  localparam int SYM_L = 8;
`endif

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam logic [3:0] CNT_LAST = 4'(SYM_L - 1);

  // Builds the on-wire symbol for one byte: the byte itself, plus a trailing
  // even-parity bit when parity is enabled.
  function automatic logic [SYM_L-1:0] encode(input logic [7:0] b);
`ifdef P2S_PARITY_EN
    return {b, ^b};
`else
    return b;
`endif
  endfunction

  logic [7:0]       hold_p0;
  logic             hold_full_p0;
  logic [SYM_L-1:0] shift_p1;
  logic [3:0]       cnt_p1;
  logic             sync_p1;
  logic             is_data_p1;
  logic             accept;
  logic             load;

  // Ready is forced low during reset even though hold_full is also cleared,
  // so upstream never sees a handshake window while the block is held.
  assign READY_OUT   = RESET & ~hold_full_p0;
  assign accept      = VALID_IN & READY_OUT;
  assign load        = (cnt_p1 == CNT_LAST);

  assign DATA_OUT    = shift_p1[SYM_L-1];
  assign SYNC_OUT    = sync_p1;
  assign IS_DATA_OUT = is_data_p1;

  // Stage 0: holding register. An accept can only happen while hold is
  // empty, and a load only drains hold while it is full, so the two never
  // collide on the same edge. A byte accepted on a load edge waits for the
  // next load (no bypass into the shifter).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_p0      <= '0;
      hold_full_p0 <= 1'b0;
    end else begin
      if (accept) begin
        hold_p0      <= DATA_IN;
        hold_full_p0 <= 1'b1;
      end else if (load && hold_full_p0) begin
        hold_full_p0 <= 1'b0;
      end
    end
  end

  // Stage 1: symbol shifter and bit counter. The counter resets to the last
  // bit position so the first edge out of reset is a load, which starts the
  // stream with a comma.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shift_p1   <= '0;
      cnt_p1     <= CNT_LAST;
      sync_p1    <= 1'b0;
      is_data_p1 <= 1'b0;
    end else if (load) begin
      if (hold_full_p0) begin
        shift_p1   <= encode(hold_p0);
        is_data_p1 <= 1'b1;
      end else begin
        shift_p1   <= encode(COMMA);
        is_data_p1 <= 1'b0;
      end
      cnt_p1  <= '0;
      sync_p1 <= 1'b1;
    end else begin
      shift_p1 <= {shift_p1[SYM_L-2:0], 1'b0};
      cnt_p1   <= cnt_p1 + 4'd1;
      sync_p1  <= 1'b0;
    end
  end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 SHALL: CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: RESET  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-003 SHALL: DATA_IN  input  8  parallel byte offered upstream.
REQ-004 SHALL: VALID_IN  input  1  DATA_IN valid; byte accepted on a rising edge with VALID_IN=1 and READY_OUT=1.
REQ-005 SHALL: READY_OUT  output  1  holding register empty; can accept a byte.
REQ-006 SHALL: DATA_OUT  output  1  serial bit stream, MSB first, one bit per CLK; feeds the serial_to_parallel DATA_IN.
REQ-007 SHALL: SYNC_OUT  output  1  high during the first bit of every symbol.
REQ-008 SHALL: IS_DATA_OUT  output  1  high for every bit of a symbol taken from the holding register; low for comma symbols.

Function
REQ-009 SHALL: contain an 8-bit holding register with a full flag, a shift register, and a bit counter; symbol length L = 8, or 9 with parity (REQ-024).
REQ-010 SHALL: READY_OUT = NOT hold_full, and 0 while RESET=0.
REQ-011 SHALL: on accept, hold <= DATA_IN and hold_full <= 1; VALID_IN without READY_OUT is ignored, and the upstream source holds DATA_IN.
REQ-012 SHALL: DATA_OUT = shift register MSB (registered output, no combinational path from inputs).
REQ-013 SHALL: on a load edge (counter = L-1), shift reg <= hold if hold_full (hold_full <= 0, IS_DATA_OUT <= 1), else the comma 0xBC (IS_DATA_OUT <= 0); counter <= 0; SYNC_OUT <= 1.
REQ-014 SHALL: on any other edge, shift left one bit, counter increments, SYNC_OUT <= 0, IS_DATA_OUT unchanged.
REQ-015 SHALL: have no bypass; a byte accepted on the same edge as a load goes to hold, the comma is loaded, and the byte is sent on the next load.
REQ-016 SHALL: latency from accept edge to first bit of that byte on DATA_OUT is 1 to L cycles, set by the next load edge.
REQ-017 SHALL: sustain full throughput of one byte per L cycles with no comma inserted, provided VALID_IN is asserted within L-1 cycles after READY_OUT rises.
REQ-018 SHALL: insert idle commas 0xBC whenever hold is empty at a load edge; data symbols are never split or truncated.
REQ-019 SHALL: READY_OUT rises on the edge after a load empties hold, and accept/load never target hold on the same edge.

Reset
REQ-020 SHALL: while RESET=0, hold <= 0, hold_full <= 0, shift reg <= 0, counter <= L-1, DATA_OUT=0, SYNC_OUT=0, IS_DATA_OUT=0, READY_OUT=0, independent of CLK.
REQ-021 SHALL: on the first rising edge after RESET deasserts, load the comma, with SYNC_OUT=1 and DATA_OUT=1.
REQ-022 SHALL: treat reset mid-symbol the same way: discard the partial symbol and any held byte; the stream restarts with a comma.

Configuration
REQ-023 SHALL: use the macro P2S_PARITY_EN to select the parity feature.
REQ-024 SHALL: with P2S_PARITY_EN defined, L = 9: 8 symbol bits MSB first, then an even-parity bit (XOR of the 8 bits), applied to data and commas (comma parity = 1).
REQ-025 SHALL: without P2S_PARITY_EN, L = 8 and no parity logic is present.

Verification
REQ-026 SHALL: idle after reset, no VALID_IN -> DATA_OUT repeats 1,0,1,1,1,1,0,0; SYNC_OUT pulses every 8 cycles; IS_DATA_OUT=0.
REQ-027 SHALL: back-to-back bytes 0xF7,0xBC,0x3D,0x0C,0x55, each offered as soon as READY_OUT=1 -> serial 11110111 10111100 00111101 00001100 01010101 contiguous, IS_DATA_OUT=1 for all 40 bits.
REQ-028 SHALL: VALID_IN held with byte 0xA5 while hold is full -> READY_OUT=0 until the next load; 0xA5 is accepted exactly once and appears exactly once.
REQ-029 SHALL: RESET asserted at bit 4 of data byte 0x3D with 0x0C held -> outputs go to reset values immediately; after release the first symbol is 0xBC and 0x0C is never sent.
REQ-030 SHALL: with P2S_PARITY_EN, byte 0xF7 -> 111101111 (parity 1); byte 0x0C -> 000011000 (parity 0); SYNC_OUT every 9 cycles.
